// File: rtl/sv32_ptw_lite.sv
// sv32_ptw_lite: Sv32 two-level hardware page-table walker for ITLB/DTLB refill.
//
// Accepts one TLB miss at a time. It reads PTEs over a valid/ready request port
// and expects exactly one response per accepted request. It then produces either
// a one-cycle TLB update pulse or a one-cycle page-fault pulse.
// An sfence flush aborts the walk. If a read is still outstanding, the walker
// drains its response first.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   satp_ppn_i            root page-table PPN
//   asid_i                ASID, captured when a miss is accepted
//   flush_i               sfence.vma abort
//   miss_*                miss request (valid/ready, instr flag, vaddr)
//   mem_req_*             PTE read request (valid/ready, physical address)
//   mem_rsp_*             PTE read response (valid, data)
//   itlb/dtlb_update_o    one-cycle refill pulses
//   update_*              refill payload (VPN, ASID, leaf PTE, superpage flag)
//   fault_o, fault_vaddr_o  one-cycle page-fault pulse and faulting vaddr
//   walking_o             walker busy
module sv32_ptw_lite #(
  parameter int unsigned ASID_WIDTH = 9,
  parameter int unsigned VLEN       = 32,
  parameter int unsigned PLEN       = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  flush_i,
  input  logic                  miss_valid_i,
  input  logic                  miss_is_instr_i,
  input  logic [VLEN-1:0]       miss_vaddr_i,
  output logic                  miss_ready_o,
  output logic                  mem_req_valid_o,
  output logic [PLEN-1:0]       mem_req_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [31:0]           mem_rsp_data_i,
  output logic                  itlb_update_o,
  output logic                  dtlb_update_o,
  output logic [19:0]           update_vpn_o,
  output logic [ASID_WIDTH-1:0] update_asid_o,
  output logic [31:0]           update_content_o,
  output logic                  update_is_4M_o,
  output logic                  fault_o,
  output logic [VLEN-1:0]       fault_vaddr_o,
  output logic                  walking_o
);

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_sv32_t;

  typedef enum logic [2:0] {
    StIdle,
    StL1Req,
    StL1Wait,
    StL0Req,
    StL0Wait,
    StUpdate,
    StFault,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [VLEN-1:0]       vaddr_q, vaddr_d;
  logic                  is_instr_q, is_instr_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  pte_sv32_t             pte_q, pte_d;
  logic                  is_4m_q, is_4m_d;

  pte_sv32_t rsp_pte;
  logic      pte_invalid;
  logic      pte_leaf;

  assign rsp_pte     = pte_sv32_t'(mem_rsp_data_i);
  assign pte_invalid = !rsp_pte.v || (!rsp_pte.r && rsp_pte.w);
  assign pte_leaf    = rsp_pte.r || rsp_pte.x;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      vaddr_q    <= '0;
      is_instr_q <= 1'b0;
      asid_q     <= '0;
      pte_q      <= '0;
      is_4m_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vaddr_q    <= vaddr_d;
      is_instr_q <= is_instr_d;
      asid_q     <= asid_d;
      pte_q      <= pte_d;
      is_4m_q    <= is_4m_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    vaddr_d         = vaddr_q;
    is_instr_d      = is_instr_q;
    asid_d          = asid_q;
    pte_d           = pte_q;
    is_4m_d         = is_4m_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    itlb_update_o   = 1'b0;
    dtlb_update_o   = 1'b0;
    fault_o         = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A flush in the same cycle wins, so do not advertise ready then.
        miss_ready_o = !flush_i;
        if (miss_valid_i && !flush_i) begin
          vaddr_d    = miss_vaddr_i;
          is_instr_d = miss_is_instr_i;
          asid_d     = asid_i;
          state_d    = StL1Req;
        end
      end

      StL1Req, StL0Req: begin
        mem_req_valid_o = 1'b1;
        if (state_q == StL1Req) begin
          mem_req_addr_o = PLEN'({satp_ppn_i, vaddr_q[31:22], 2'b00});
        end else begin
          mem_req_addr_o = PLEN'({pte_q.ppn1, pte_q.ppn0, vaddr_q[21:12], 2'b00});
        end
        if (mem_req_ready_i) begin
          // The request was accepted, so a response is owed even if we abort now.
          if (flush_i) begin
            state_d = StDrain;
          end else if (state_q == StL1Req) begin
            state_d = StL1Wait;
          end else begin
            state_d = StL0Wait;
          end
        end else if (flush_i) begin
          state_d = StIdle;
        end
      end

      StL1Wait, StL0Wait: begin
        if (mem_rsp_valid_i) begin
          if (flush_i) begin
            // The response arrives with the flush, so nothing is left to drain.
            state_d = StIdle;
          end else begin
            pte_d = rsp_pte;
            if (pte_invalid) begin
              state_d = StFault;
            end else if (pte_leaf) begin
              if (state_q == StL0Wait) begin
                is_4m_d = 1'b0;
                state_d = StUpdate;
              end else if (rsp_pte.ppn0 != '0) begin
                state_d = StFault;
              end else begin
                is_4m_d = 1'b1;
                state_d = StUpdate;
              end
            end else if (state_q == StL1Wait) begin
              state_d = StL0Req;
            end else begin
              state_d = StFault;
            end
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end

      StUpdate: begin
        itlb_update_o = is_instr_q && !flush_i;
        dtlb_update_o = !is_instr_q && !flush_i;
        state_d       = StIdle;
      end

      StFault: begin
        fault_o = !flush_i;
        state_d = StIdle;
      end

      StDrain: begin
        if (mem_rsp_valid_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign update_vpn_o     = vaddr_q[31:12];
  assign update_asid_o    = asid_q;
  assign update_content_o = pte_q;
  assign update_is_4M_o   = is_4m_q;
  assign fault_vaddr_o    = vaddr_q;
  assign walking_o        = (state_q != StIdle);

endmodule

// File: tb/tb_sv32_ptw_lite.sv
// tb_sv32_ptw_lite: self-checking bench for sv32_ptw_lite.
// A vector table drives complete walks; expected pulses are queued and a negedge monitor
// pops/compares them. Hand-written sequences cover flush, drain and mid-walk reset.
module tb_sv32_ptw_lite;

  localparam int KItlb  = 0;
  localparam int KDtlb  = 1;
  localparam int KFault = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [21:0] satp_ppn_i;
  logic [8:0]  asid_i;
  logic        flush_i;
  logic        miss_valid_i;
  logic        miss_is_instr_i;
  logic [31:0] miss_vaddr_i;
  logic        miss_ready_o;
  logic        mem_req_valid_o;
  logic [33:0] mem_req_addr_o;
  logic        mem_req_ready_i;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        itlb_update_o;
  logic        dtlb_update_o;
  logic [19:0] update_vpn_o;
  logic [8:0]  update_asid_o;
  logic [31:0] update_content_o;
  logic        update_is_4M_o;
  logic        fault_o;
  logic [31:0] fault_vaddr_o;
  logic        walking_o;

  sv32_ptw_lite #(
    .ASID_WIDTH(9),
    .VLEN      (32),
    .PLEN      (34)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .satp_ppn_i      (satp_ppn_i),
    .asid_i          (asid_i),
    .flush_i         (flush_i),
    .miss_valid_i    (miss_valid_i),
    .miss_is_instr_i (miss_is_instr_i),
    .miss_vaddr_i    (miss_vaddr_i),
    .miss_ready_o    (miss_ready_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .itlb_update_o   (itlb_update_o),
    .dtlb_update_o   (dtlb_update_o),
    .update_vpn_o    (update_vpn_o),
    .update_asid_o   (update_asid_o),
    .update_content_o(update_content_o),
    .update_is_4M_o  (update_is_4M_o),
    .fault_o         (fault_o),
    .fault_vaddr_o   (fault_vaddr_o),
    .walking_o       (walking_o)
  );

  typedef struct {
    logic        is_instr;
    logic [31:0] vaddr;
    logic [21:0] satp;
    logic [8:0]  asid;
    logic [31:0] l1_pte;
    logic [31:0] l0_pte;
    int          stall;
    int          nreq;
    int          kind;
    logic [31:0] content;
    logic        is4m;
  } vec_t;

  typedef struct {
    int          kind;
    logic [19:0] vpn;
    logic [8:0]  asid;
    logic [31:0] content;
    logic        is4m;
    logic [31:0] fvaddr;
    int          cyc;
  } exp_t;

  exp_t res_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial forever #5 clk_i = ~clk_i;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] l1_addr(input logic [21:0] satp, input logic [31:0] va);
    return {satp, va[31:22], 2'b00};
  endfunction

  function automatic logic [33:0] l0_addr(input logic [31:0] pte, input logic [31:0] va);
    return {pte[31:10], va[21:12], 2'b00};
  endfunction

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  initial forever begin
    @(negedge clk_i);
    if (itlb_update_o || dtlb_update_o || fault_o) begin
      if (res_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got itlb=%b dtlb=%b fault=%b required none",
                 itlb_update_o, dtlb_update_o, fault_o);
      end else begin
        exp_t e;
        int   k;
        e = res_q.pop_front();
        k = fault_o ? KFault : (dtlb_update_o ? KDtlb : KItlb);
        chk("pulse_onehot", 64'(int'(itlb_update_o) + int'(dtlb_update_o) + int'(fault_o)), 1);
        chk("pulse_kind", 64'(k), 64'(e.kind));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        if (e.kind == KFault) begin
          chk("fault_vaddr", 64'(fault_vaddr_o), 64'(e.fvaddr));
        end else begin
          chk("upd_vpn", 64'(update_vpn_o), 64'(e.vpn));
          chk("upd_asid", 64'(update_asid_o), 64'(e.asid));
          chk("upd_content", 64'(update_content_o), 64'(e.content));
          chk("upd_is_4M", 64'(update_is_4M_o), 64'(e.is4m));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(input logic [33:0] exp_a, input int stall, input string tag);
    int w = 0;
    while (mem_req_valid_o !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk({tag, "_req_valid"}, 64'(mem_req_valid_o), 1);
    for (int s = 0; s < stall; s++) begin
      if (s == 0) begin
        miss_valid_i = 1'b1;
        miss_vaddr_i = 32'hDEAD_B000;
      end
      step();
      chk({tag, "_hold_valid"}, 64'(mem_req_valid_o), 1);
      chk({tag, "_hold_addr"}, 64'(mem_req_addr_o), 64'(exp_a));
      chk({tag, "_busy_not_ready"}, 64'(miss_ready_o), 0);
    end
    miss_valid_i = 1'b0;
    chk({tag, "_addr"}, 64'(mem_req_addr_o), 64'(exp_a));
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
  endtask

  task automatic do_rsp(input logic [31:0] data);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = data;
    step();
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
  endtask

  task automatic start_miss(input logic is_instr, input logic [31:0] va);
    miss_valid_i    = 1'b1;
    miss_is_instr_i = is_instr;
    miss_vaddr_i    = va;
    step();
    miss_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    chk("idle_ready", 64'(miss_ready_o), 1);
    satp_ppn_i = v.satp;
    asid_i     = v.asid;
    e.kind     = v.kind;
    e.vpn      = v.vaddr[31:12];
    e.asid     = v.asid;
    e.content  = v.content;
    e.is4m     = v.is4m;
    e.fvaddr   = v.vaddr;
    e.cyc      = cyc + 3 + 2 * (v.nreq - 1) + v.stall;
    res_q.push_back(e);
    start_miss(v.is_instr, v.vaddr);
    asid_i = ~v.asid;
    chk("walking", 64'(walking_o), 1);
    do_req(l1_addr(v.satp, v.vaddr), v.stall, "l1");
    do_rsp(v.l1_pte);
    if (v.nreq == 2) begin
      do_req(l0_addr(v.l1_pte, v.vaddr), 0, "l0");
      do_rsp(v.l0_pte);
    end
    chk("no_extra_req", 64'(mem_req_valid_o), 0);
    step();
    chk("back_idle", 64'(walking_o), 0);
  endtask

  initial begin
    rst_i           = 1'b1;
    satp_ppn_i      = '0;
    asid_i          = '0;
    flush_i         = 1'b0;
    miss_valid_i    = 1'b0;
    miss_is_instr_i = 1'b0;
    miss_vaddr_i    = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;

    //           instr vaddr         satp       asid   l1_pte        l0_pte        st n kind    content       4M
    vecs[0] = '{1'b0, 32'h0040_3000, 22'h00001, 9'h005, 32'h0000_0801, 32'h0012_34CF, 0, 2, KDtlb,
                32'h0012_34CF, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_0000, 22'h0002A, 9'h1FF, 32'h2000_00CB, 32'h0, 0, 1, KItlb,
                32'h2000_00CB, 1'b1};
    vecs[2] = '{1'b0, 32'h1234_5678, 22'h00010, 9'h011, 32'h0000_0400, 32'h0, 0, 1, KFault,
                32'h0, 1'b0};
    vecs[3] = '{1'b1, 32'h00C0_0000, 22'h00010, 9'h022, 32'h0000_04CF, 32'h0, 0, 1, KFault,
                32'h0, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_1000, 22'h00020, 9'h033, 32'h0000_0005, 32'h0, 0, 1, KFault,
                32'h0, 1'b0};
    vecs[5] = '{1'b0, 32'h0123_4000, 22'h00030, 9'h044, 32'h0000_0C01, 32'h0000_0001, 0, 2,
                KFault, 32'h0, 1'b0};
    vecs[6] = '{1'b1, 32'h0FFF_F000, 22'h00040, 9'h055, 32'h0000_0C01, 32'h0000_0005, 0, 2,
                KFault, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_F000, 22'h3FFFFF, 9'h0AA, 32'hFFFF_FC01, 32'h0000_00CB, 5, 2,
                KItlb, 32'h0000_00CB, 1'b0};
    vecs[8] = '{1'b0, 32'h7FC0_1234, 22'h00123, 9'h100, 32'h0040_0009, 32'h0, 0, 1, KDtlb,
                32'h0040_0009, 1'b1};

    step();
    step();
    chk("rst_ready", 64'(miss_ready_o), 1);
    chk("rst_walking", 64'(walking_o), 0);
    chk("rst_req_valid", 64'(mem_req_valid_o), 0);
    chk("rst_content", 64'(update_content_o), 0);
    chk("rst_vpn", 64'(update_vpn_o), 0);
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
    end

    // Flush in L1_WAIT: the outstanding response is drained silently.
    satp_ppn_i = 22'h00001;
    start_miss(1'b0, 32'h0040_3000);
    do_req(l1_addr(22'h00001, 32'h0040_3000), 0, "drain_l1");
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("drain_busy", 64'(walking_o), 1);
    chk("drain_not_ready", 64'(miss_ready_o), 0);
    chk("drain_no_req", 64'(mem_req_valid_o), 0);
    do_rsp(32'h2000_00CB);
    chk("drain_ready_after_rsp", 64'(miss_ready_o), 1);
    step();
    step();

    // Flush in L1_REQ without handshake drops the request.
    start_miss(1'b1, 32'h8000_0000);
    chk("flreq_valid", 64'(mem_req_valid_o), 1);
    flush_i = 1'b1;
    step();
    chk("flreq_idle", 64'(walking_o), 0);
    // Flush together with a miss in IDLE: flush wins.
    miss_valid_i = 1'b1;
    chk("flidle_not_ready", 64'(miss_ready_o), 0);
    step();
    chk("flidle_not_accepted", 64'(walking_o), 0);
    flush_i      = 1'b0;
    miss_valid_i = 1'b0;
    step();

    // Flush during the UPDATE cycle suppresses the pulse.
    start_miss(1'b1, 32'h8000_0000);
    do_req(l1_addr(22'h00001, 32'h8000_0000), 0, "flupd");
    do_rsp(32'h2000_00CB);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flupd_idle", 64'(walking_o), 0);

    // Reset asserted in L0_WAIT; the late response must be ignored.
    satp_ppn_i = 22'h00002;
    asid_i     = 9'h0F0;
    start_miss(1'b0, 32'h0040_3000);
    do_req(l1_addr(22'h00002, 32'h0040_3000), 0, "rst_l1");
    do_rsp(32'h0000_0801);
    do_req(l0_addr(32'h0000_0801, 32'h0040_3000), 0, "rst_l0");
    chk("rst_pre_busy", 64'(walking_o), 1);
    rst_i = 1'b1;
    #1;
    chk("rstmid_walking", 64'(walking_o), 0);
    chk("rstmid_ready", 64'(miss_ready_o), 1);
    chk("rstmid_req_valid", 64'(mem_req_valid_o), 0);
    chk("rstmid_content", 64'(update_content_o), 0);
    chk("rstmid_vpn", 64'(update_vpn_o), 0);
    chk("rstmid_asid", 64'(update_asid_o), 0);
    chk("rstmid_fault_vaddr", 64'(fault_vaddr_o), 0);
    step();
    rst_i = 1'b0;
    do_rsp(32'h0012_34CF);
    chk("rst_late_rsp_idle", 64'(walking_o), 0);
    step();
    step();

    chk("queue_drained", 64'(res_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
